// File: rtl/ps2_pkg.sv
// Shared definitions for the ASCII-to-PS/2 keyboard emulator: scan codes, frame size, FSM states.
// PS2TX_BREAK_EN adds the break prefix constant used by the make/F0/make sequence.
package ps2_pkg;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

`ifdef PS2TX_BREAK_EN
  localparam logic [7:0] PS2_BREAK = 8'hF0;
`endif

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Frame bits after the start bit, LSB shifted out first: data, odd parity, stop.
  function automatic logic [9:0] frame_payload(input logic [7:0] code);
    return {1'b1, ~^code, code};
  endfunction

endpackage

// File: rtl/ascii_to_scan.sv
// Combinational ASCII (0-9, A-F) to PS/2 set-2 make-code lookup.
// valid is low for any character outside those sixteen.
module ascii_to_scan
  import ps2_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] code,
  output logic       valid
);

  always_comb begin
    code  = 8'h00;
    valid = 1'b1;
    case (ascii)
      8'h30:   code = SC_0;
      8'h31:   code = SC_1;
      8'h32:   code = SC_2;
      8'h33:   code = SC_3;
      8'h34:   code = SC_4;
      8'h35:   code = SC_5;
      8'h36:   code = SC_6;
      8'h37:   code = SC_7;
      8'h38:   code = SC_8;
      8'h39:   code = SC_9;
      8'h41:   code = SC_A;
      8'h42:   code = SC_B;
      8'h43:   code = SC_C;
      8'h44:   code = SC_D;
      8'h45:   code = SC_E;
      8'h46:   code = SC_F;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ascii_to_ps2_tx.sv
// Keyboard emulator: accepts an ASCII hex digit and sends its scan code as PS/2 device-to-host frames.
// Define PS2TX_BREAK_EN to send make, F0, make per key instead of the make code alone.
module ascii_to_ps2_tx
  import ps2_pkg::*;
#(
  parameter int HALF_DIV = 2500,
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       err
);

  localparam int DIV_W      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int GAP_CYCLES = GAP_BITS * 2 * HALF_DIV;
  localparam int GAP_W      = $clog2(GAP_CYCLES);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic             low_phase_reg;
  logic [3:0]       bit_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [9:0]       shift_reg;
  logic             ps2_clk_reg;
  logic             ps2_data_reg;
  logic             in_ready_reg;
  logic             busy_reg;
  logic             err_reg;

`ifdef PS2TX_BREAK_EN
  localparam logic [1:0] BYTE_LAST = 2'd2;
  logic [1:0] byte_reg;
  logic [7:0] make_reg;
`endif

  logic [7:0] scan_code;
  logic       scan_valid;

  ascii_to_scan u_map (
    .ascii (in_data),
    .code  (scan_code),
    .valid (scan_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      low_phase_reg <= 1'b0;
      bit_reg       <= 4'd0;
      gap_reg       <= '0;
      shift_reg     <= '1;
      ps2_clk_reg   <= 1'b1;
      ps2_data_reg  <= 1'b1;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
`ifdef PS2TX_BREAK_EN
      byte_reg      <= 2'd0;
      make_reg      <= 8'h00;
`endif
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          ps2_clk_reg  <= 1'b1;
          ps2_data_reg <= 1'b1;
          busy_reg     <= 1'b0;
          in_ready_reg <= 1'b1;
          if (in_valid && in_ready_reg) begin
            in_ready_reg <= 1'b0;
            if (scan_valid) begin
              // Start bit goes out on the accepting edge itself.
              state_reg     <= FRAME;
              busy_reg      <= 1'b1;
              ps2_data_reg  <= 1'b0;
              shift_reg     <= frame_payload(scan_code);
              div_reg       <= '0;
              low_phase_reg <= 1'b0;
              bit_reg       <= 4'd0;
`ifdef PS2TX_BREAK_EN
              make_reg      <= scan_code;
              byte_reg      <= 2'd0;
`endif
            end else begin
              err_reg <= 1'b1;
            end
          end
        end

        FRAME: begin
          if (div_reg == DIV_LAST) begin
            div_reg <= '0;
            if (!low_phase_reg) begin
              ps2_clk_reg   <= 1'b0;
              low_phase_reg <= 1'b1;
            end else begin
              // End of a bit: data only moves here, while the clock goes back high.
              low_phase_reg <= 1'b0;
              ps2_clk_reg   <= 1'b1;
              if (bit_reg == BIT_LAST) begin
                state_reg    <= GAP;
                gap_reg      <= '0;
                ps2_data_reg <= 1'b1;
              end else begin
                bit_reg      <= bit_reg + 4'd1;
                ps2_data_reg <= shift_reg[0];
                shift_reg    <= {1'b1, shift_reg[9:1]};
              end
            end
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end

        GAP: begin
          if (gap_reg == GAP_LAST) begin
`ifdef PS2TX_BREAK_EN
            if (byte_reg != BYTE_LAST) begin
              // Byte 1 is the break prefix, byte 2 repeats the make code.
              byte_reg      <= byte_reg + 2'd1;
              state_reg     <= FRAME;
              ps2_data_reg  <= 1'b0;
              div_reg       <= '0;
              low_phase_reg <= 1'b0;
              bit_reg       <= 4'd0;
              shift_reg     <= frame_payload((byte_reg == 2'd0) ? PS2_BREAK : make_reg);
            end else begin
              state_reg    <= IDLE;
              in_ready_reg <= 1'b1;
              busy_reg     <= 1'b0;
            end
`else
            state_reg    <= IDLE;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
`endif
          end else begin
            gap_reg <= gap_reg + GAP_W'(1);
          end
        end

        default: begin
          state_reg    <= IDLE;
          ps2_clk_reg  <= 1'b1;
          ps2_data_reg <= 1'b1;
          in_ready_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_reg;
  assign ps2_clk  = ps2_clk_reg;
  assign ps2_data = ps2_data_reg;
  assign busy     = busy_reg;
  assign err      = err_reg;

endmodule

// File: doc/ascii_to_ps2_tx.md
Name: ascii_to_ps2_tx

Overview:
- Inverse of the keyboard receive path: accepts one ASCII character (0-9, A-F) per handshake, maps it to its PS/2 set-2 scan code, and serialises it as device-to-host PS/2 frames on ps2_clk/ps2_data.
- Used as a keyboard emulator so the encrypt/decrypt datapath can be driven and looped back without a physical keyboard.
- Outputs are push-pull levels; open-drain handling is done at the pad level, outside this block.

Parameters:
- HALF_DIV, 2500: system clocks per PS/2 clock half-period (10 kHz at 50 MHz); minimum 2.
- GAP_BITS, 2: idle bit-periods inserted after every transmitted byte; minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- in_data  in  8  ASCII character.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a character.
- ps2_clk  out  1  PS/2 clock line level; idles high.
- ps2_data  out  1  PS/2 data line level; idles high.
- busy  out  1  high from acceptance until in_ready returns high.
- err  out  1  one-cycle pulse when an accepted character is unmappable.

Behaviour:
- One clock, clk. Reset is synchronous and active-low: all state is sampled on the rising edge of clk while reset_n=0.
- Reset values (registered outputs): in_ready=1, ps2_clk=1, ps2_data=1, busy=0, err=0. State returns to IDLE.
- Reset mid-frame aborts the transfer immediately. Both lines are high on the edge after reset_n is sampled low. No partial frame resumes.
- Mapping ASCII -> scan code:
  - 30->45, 31->16, 32->1E, 33->26, 34->25, 35->2E, 36->36, 37->3D, 38->3E, 39->46.
  - 41->1C, 42->32, 43->21, 44->23, 45->24, 46->2B.
  - Any other value is unmappable.
- Handshake: a transfer is accepted on a clock edge where in_valid=1 and in_ready=1. in_ready is high only in IDLE.
- States:
  - IDLE: lines high.
  - On accept of a mappable character: in_ready=0, busy=1, go to FRAME.
  - On accept of an unmappable character: err=1 for exactly one cycle; in_ready is 0 for that cycle and busy stays 0; return to IDLE with no line activity.
  - FRAME: shifts one 11-bit frame, in order: start=0, data bits 0..7 (LSB first), odd parity, stop=1.
    - Each bit occupies 2*HALF_DIV cycles.
    - ps2_data changes at bit start while ps2_clk=1.
    - ps2_clk is 1 for HALF_DIV cycles, then 0 for HALF_DIV cycles. The host samples on the falling edge.
  - GAP: both lines high for GAP_BITS*2*HALF_DIV cycles.
    - Then either the next byte of the sequence goes to FRAME, or, after the last byte, the block returns to IDLE with in_ready=1 and busy=0.
- Byte sequence per key: make code; then, with the optional feature, F0 followed by the make code again.
- Latency: ps2_data falls (start bit) on the first edge after acceptance. ps2_clk first falls HALF_DIV cycles later.
- Parity is odd over the 8 data bits: the parity bit is 1 when the data contains an even number of ones.
- Counters: the divider counts 0..HALF_DIV-1 and wraps; the bit index runs 0..10; the byte index runs 0..2. in_data is latched at acceptance, so later changes on in_data are ignored.
- in_valid held high during a transfer is ignored until IDLE.

Optional Feature:
- Macro PS2TX_BREAK_EN.
- Defined: each key sends three frames (make, F0, make), each followed by a gap.
- Undefined: each key sends only the make frame plus one gap. Byte-index logic and the F0 constant are compiled out.

Decomposition:
- Package ps2_pkg holds:
  - scan-code localparams for 0-9 and A-F;
  - PS2_BREAK = 8'hF0;
  - FRAME_BITS = 11;
  - state encoding IDLE/FRAME/GAP.
- Sub-module ascii_to_scan: combinational, takes 8-bit ASCII, returns 8-bit code plus a valid bit. The top module holds the FSM, divider and shifter.

Test Plan (HALF_DIV=4, GAP_BITS=2):
- Reset: hold reset_n=0 for 3 cycles, including once mid-frame -> next edge shows ps2_clk=1, ps2_data=1, in_ready=1, busy=0, err=0.
- Send 8'h35 ('5') without PS2TX_BREAK_EN -> one frame with bits 0,0,1,1,1,0,1,0,0,1,1 (scan 2E, parity 1) sampled on 11 falling edges. in_ready returns after 88+16=104 cycles.
- Send 8'h41 ('A') with PS2TX_BREAK_EN -> three frames:
  - 1C with parity 0;
  - F0 with parity 1;
  - 1C with parity 0.
  busy is high for 312 cycles.
- Send 8'h78 ('x') -> err high for exactly 1 cycle, no ps2_clk transitions, in_ready=1 two cycles after acceptance.
- Back-to-back: in_valid held high with '0' then '9' -> second accept only after the gap. Frames decode to 45 then 46 with no overlap. in_data changed mid-frame has no effect.
- Bit timing: measure every ps2_clk low and high phase = 4 cycles. ps2_data is never toggled while ps2_clk=0.
